// File: rtl/voice_note_alloc.sv
// rtl/voice_note_alloc.sv - voice allocator: retrigger, free voice, round-robin steal
module voice_note_alloc #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset_reg_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [6:0]         ev_key,
  input  logic [7:0]         ev_vel,
  input  logic               all_notes_off,
  output logic               reg_note_on,
  output logic               reg_note_off,
  output logic [V_WIDTH-1:0] reg_cur_key_adr,
  output logic [7:0]         reg_cur_vel_on,
  output logic [VOICES-1:0]  voice_active
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] STROBE = 2'd3;

  logic [1:0]         state;
  logic [6:0]         key_tab [VOICES];
  logic [V_WIDTH-1:0] steal_ptr;
  logic [V_WIDTH-1:0] scan_idx;
  logic [V_WIDTH-1:0] match_idx;
  logic [V_WIDTH-1:0] free_idx;
  logic               match_found;
  logic               free_found;
  logic               lat_on;
  logic [6:0]         lat_key;
  logic [7:0]         lat_vel;
  // run_en gates ev_ready until the first edge after reset release;
  // settle holds ev_ready low during the strobe-high cycle so every
  // event type sees the same turnaround.
  logic               run_en;
  logic               settle;
  logic [V_WIDTH-1:0] target;
  logic               accept;

  assign ev_ready = run_en && !settle && (state == IDLE) && !all_notes_off;
  assign accept   = ev_valid && ev_ready;

  // Note-on target choice: retrigger beats free voice beats steal.
  always_comb begin
    target = steal_ptr;
    if (match_found)     target = match_idx;
    else if (free_found) target = free_idx;
  end

  // Key table is cleared at reset so a fresh start never matches stale keys.
  always_ff @(posedge clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int i = 0; i < VOICES; i++) key_tab[i] <= 7'd0;
    end else if (state == COMMIT && lat_on) begin
      key_tab[target] <= lat_key;
    end
  end

  // Allocation FSM, voice flags and registered strobes.
  always_ff @(posedge clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state           <= IDLE;
      voice_active    <= '0;
      steal_ptr       <= '0;
      scan_idx        <= '0;
      match_idx       <= '0;
      free_idx        <= '0;
      match_found     <= 1'b0;
      free_found      <= 1'b0;
      lat_on          <= 1'b0;
      lat_key         <= 7'd0;
      lat_vel         <= 8'd0;
      run_en          <= 1'b0;
      settle          <= 1'b0;
      reg_note_on     <= 1'b0;
      reg_note_off    <= 1'b0;
      reg_cur_key_adr <= '0;
      reg_cur_vel_on  <= 8'd0;
    end else begin
      run_en       <= 1'b1;
      settle       <= 1'b0;
      reg_note_on  <= 1'b0;
      reg_note_off <= 1'b0;
      case (state)
        IDLE: begin
          if (all_notes_off) begin
            voice_active <= '0;
          end else if (accept) begin
            // A zero-velocity note-on is a note-off by MIDI convention.
            lat_on      <= ev_on && (ev_vel != 8'd0);
            lat_key     <= ev_key;
            lat_vel     <= ev_vel;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            scan_idx    <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (!match_found && voice_active[scan_idx] && key_tab[scan_idx] == lat_key) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!free_found && !voice_active[scan_idx]) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == V_WIDTH'(VOICES - 1)) state <= COMMIT;
        end
        COMMIT: begin
          if (lat_on) begin
            voice_active[target] <= 1'b1;
            reg_cur_key_adr      <= target;
            reg_cur_vel_on       <= lat_vel;
            if (!match_found && !free_found) steal_ptr <= steal_ptr + 1'b1;
          end else if (match_found) begin
            voice_active[match_idx] <= 1'b0;
            reg_cur_key_adr         <= match_idx;
          end
          state <= STROBE;
        end
        default: begin
          reg_note_on  <= lat_on;
          reg_note_off <= !lat_on && match_found;
          settle       <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_note_alloc.sv
// tb/tb_voice_note_alloc.sv - self-checking bench for voice_note_alloc
module tb_voice_note_alloc;

  logic        clk = 1'b0;
  logic        reset_reg_N = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_key = 7'd0;
  logic [7:0]  ev_vel = 8'd0;
  logic        all_notes_off = 1'b0;
  logic        reg_note_on;
  logic        reg_note_off;
  logic [4:0]  reg_cur_key_adr;
  logic [7:0]  reg_cur_vel_on;
  logic [31:0] voice_active;

  voice_note_alloc #(.VOICES(32), .V_WIDTH(5)) dut (
    .clk(clk), .reset_reg_N(reset_reg_N), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_key(ev_key), .ev_vel(ev_vel), .all_notes_off(all_notes_off),
    .reg_note_on(reg_note_on), .reg_note_off(reg_note_off),
    .reg_cur_key_adr(reg_cur_key_adr), .reg_cur_vel_on(reg_cur_vel_on),
    .voice_active(voice_active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        on;
    logic [6:0]  key;
    logic [7:0]  vel;
    logic [4:0]  adr;
    logic [7:0]  evel;
    logic        pon;
    logic        poff;
    logic [31:0] act;
  } vec_t;

  vec_t tbl [6];

  // Reference model: which key each voice holds and whether it sounds.
  logic [6:0]  mkey [32];
  logic [31:0] mact;
  int          msteal;
  logic [4:0]  madr;
  logic [7:0]  mvel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mkey[i] = 7'd0;
    mact = '0; msteal = 0; madr = '0; mvel = '0;
  endtask

  task automatic model_step(input logic on, input logic [6:0] key, input logic [7:0] vel,
                            output logic [4:0] eadr, output logic [7:0] evel,
                            output logic pon, output logic poff, output logic [31:0] eact);
    int m, f, t;
    m = -1; f = -1;
    for (int i = 0; i < 32; i++) begin
      if (m < 0 && mact[i] && mkey[i] == key) m = i;
      if (f < 0 && !mact[i]) f = i;
    end
    pon = 1'b0; poff = 1'b0;
    if (on && vel != 0) begin
      if (m >= 0) t = m;
      else if (f >= 0) t = f;
      else begin t = msteal; msteal = (msteal + 1) % 32; end
      mkey[t] = key; mact[t] = 1'b1; madr = 5'(t); mvel = vel; pon = 1'b1;
    end else if (m >= 0) begin
      mact[m] = 1'b0; madr = 5'(m); poff = 1'b1;
    end
    eadr = madr; evel = mvel; eact = mact;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!ev_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!ev_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic do_event(input logic on, input logic [6:0] key, input logic [7:0] vel,
                          input logic [4:0] eadr, input logic [7:0] evel,
                          input logic epon, input logic epoff, input logic [31:0] eact,
                          output logic [4:0] got_adr);
    int on_cnt, off_cnt, on_first, off_first;
    logic [4:0] adr33, adr34;
    logic [7:0] vel33;
    logic rdy34, rdy35;
    wait_ready();
    ev_valid = 1'b1; ev_on = on; ev_key = key; ev_vel = vel;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    on_cnt = 0; off_cnt = 0; on_first = -1; off_first = -1;
    adr33 = '0; adr34 = '0; vel33 = '0; rdy34 = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (c == 33) begin adr33 = reg_cur_key_adr; vel33 = reg_cur_vel_on; end
      if (c == 34) begin adr34 = reg_cur_key_adr; rdy34 = ev_ready; end
      if (reg_note_on)  begin on_cnt++;  if (on_first < 0)  on_first = c;  end
      if (reg_note_off) begin off_cnt++; if (off_first < 0) off_first = c; end
    end
    rdy35 = ev_ready;
    check("adr_at_commit", adr33, eadr);
    check("vel_at_commit", vel33, evel);
    check("adr_held_at_strobe", adr34, eadr);
    check("note_on_count", on_cnt, epon);
    if (epon) check("note_on_rise", on_first, 34);
    check("note_off_count", off_cnt, epoff);
    if (epoff) check("note_off_rise", off_first, 34);
    check("ready_low_in_strobe", rdy34, 0);
    check("ready_back", rdy35, 1);
    check("voice_active", voice_active, eact);
    got_adr = adr33;
  endtask

  task automatic model_event(input logic on, input logic [6:0] key, input logic [7:0] vel,
                             output logic [4:0] got_adr);
    logic [4:0] a; logic [7:0] v; logic p, q; logic [31:0] ac;
    model_step(on, key, vel, a, v, p, q, ac);
    do_event(on, key, vel, a, v, p, q, ac, got_adr);
  endtask

  task automatic anf_test(input string tag);
    wait_ready();
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd5; ev_vel = 8'd9;
    all_notes_off = 1'b1;
    #1;
    check({tag, "_ready_low"}, ev_ready, 0);
    @(posedge clk); #1;
    check({tag, "_active_clear"}, voice_active, 0);
    check({tag, "_no_on"}, reg_note_on, 0);
    check({tag, "_no_off"}, reg_note_off, 0);
    all_notes_off = 1'b0; ev_valid = 1'b0;
    #1;
    check({tag, "_ready_after"}, ev_ready, 1);
    mact = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] ga;
    int strobes;
    logic [6:0] rk;
    logic ro;
    logic [7:0] rv;

    tbl[0] = '{1'b1, 7'd60, 8'd100, 5'd0, 8'd100, 1'b1, 1'b0, 32'h1};
    tbl[1] = '{1'b1, 7'd62, 8'd80,  5'd1, 8'd80,  1'b1, 1'b0, 32'h3};
    tbl[2] = '{1'b1, 7'd60, 8'd50,  5'd0, 8'd50,  1'b1, 1'b0, 32'h3};
    tbl[3] = '{1'b0, 7'd60, 8'd0,   5'd0, 8'd50,  1'b0, 1'b1, 32'h2};
    tbl[4] = '{1'b0, 7'd99, 8'd0,   5'd0, 8'd50,  1'b0, 1'b0, 32'h2};
    tbl[5] = '{1'b1, 7'd62, 8'd0,   5'd1, 8'd50,  1'b0, 1'b1, 32'h0};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ev_ready, 0);
    check("rst_active", voice_active, 0);
    check("rst_outs", {reg_note_on, reg_note_off, reg_cur_key_adr, reg_cur_vel_on}, 0);
    reset_reg_N = 1'b1;
    #1;
    check("ready_before_first_edge", ev_ready, 0);
    @(posedge clk); #1;
    check("ready_after_first_edge", ev_ready, 1);

    for (int i = 0; i < 6; i++) begin
      logic [4:0] a; logic [7:0] v; logic p, q; logic [31:0] ac;
      model_step(tbl[i].on, tbl[i].key, tbl[i].vel, a, v, p, q, ac);
      do_event(tbl[i].on, tbl[i].key, tbl[i].vel, tbl[i].adr, tbl[i].evel,
               tbl[i].pon, tbl[i].poff, tbl[i].act, ga);
    end

    for (int k = 0; k < 32; k++) model_event(1'b1, 7'(k), 8'(k + 1), ga);
    for (int s = 0; s < 33; s++) begin
      model_event(1'b1, 7'(40 + s), 8'd70, ga);
      if (s == 0)  check("steal_first", ga, 0);
      if (s == 1)  check("steal_second", ga, 1);
      if (s == 32) check("steal_wrap", ga, 0);
    end

    anf_test("anf_full");
    for (int k = 0; k < 5; k++) model_event(1'b1, 7'(20 + k), 8'd33, ga);
    check("five_active", voice_active, 32'h1f);
    anf_test("anf_five");

    for (int r = 0; r < 40; r++) begin
      rk = 7'($urandom_range(0, 40));
      ro = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
      model_event(ro, rk, rv, ga);
    end

    wait_ready();
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd9; ev_vel = 8'd7;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_reg_N = 1'b0;
    #1;
    check("midscan_active", voice_active, 0);
    check("midscan_ready", ev_ready, 0);
    check("midscan_outs", {reg_note_on, reg_note_off, reg_cur_key_adr, reg_cur_vel_on}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_reg_N = 1'b1;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (reg_note_on || reg_note_off) strobes++;
    end
    check("midscan_no_strobe", strobes, 0);
    model_reset();
    model_event(1'b1, 7'd9, 8'd7, ga);
    check("post_reset_adr", ga, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voice_note_alloc.md
Name: voice_note_alloc

Overview:
- Voice allocator/scheduler for the per-voice velocity store and level scaling path.
- Accepts serialized MIDI note events, tracks which key each voice plays, and picks a target voice for each note-on: retrigger, then free voice, then round-robin steal.
- Drives the write strobe, voice address and velocity consumed by the velocity register file. Also emits a note-off strobe for the envelope logic.

Parameters:
- VOICES, 32, number of voices; must equal 2**V_WIDTH.
- V_WIDTH, 5, voice index width.

Ports:
- clk  input  1  system clock
- reset_reg_N  input  1  reset, asynchronous, active-low
- ev_valid  input  1  note event present
- ev_ready  output  1  allocator can accept an event this cycle
- ev_on  input  1  1 = note-on, 0 = note-off
- ev_key  input  7  MIDI key number
- ev_vel  input  8  note-on velocity
- all_notes_off  input  1  clear all voices; sampled only in IDLE
- reg_note_on  output  1  one-clock note-on write strobe
- reg_note_off  output  1  one-clock note-off strobe
- reg_cur_key_adr  output  V_WIDTH  target voice index
- reg_cur_vel_on  output  8  velocity for target voice
- voice_active  output  VOICES  per-voice gate/active flags

Behaviour:
- Internal state: key table (VOICES x 7), active bits (= voice_active), steal_ptr (V_WIDTH), latched event, scan_idx, match/free flags and indices.
- Reset values while reset_reg_N low (async assert):
  - voice_active=0, key table=0, steal_ptr=0.
  - reg_note_on=0, reg_note_off=0, reg_cur_key_adr=0, reg_cur_vel_on=0, ev_ready=0.
  - FSM forced to IDLE.
- Reset release: state IDLE; ev_ready is 1 from the first clock edge after release.
- Reset mid-operation: any in-flight event is dropped and no strobe is emitted.
- FSM states: IDLE, SCAN, COMMIT, STROBE.
- IDLE:
  - ev_ready=1 unless all_notes_off=1.
  - all_notes_off=1 has priority: ev_ready=0, all active bits clear at the next edge, no strobes, stay IDLE.
  - Otherwise ev_valid&ev_ready latches ev_on/ev_key/ev_vel, clears match/free flags, sets scan_idx=0, goes to SCAN.
  - A note-on with ev_vel==0 is latched as a note-off.
- SCAN:
  - Exactly VOICES clocks, one voice per clock, scan_idx 0..VOICES-1.
  - match = first voice (lowest index) with active=1 and key==latched key.
  - free = first voice with active=0.
  - After scan_idx==VOICES-1, go to COMMIT. ev_ready=0.
- COMMIT (one clock), note-on:
  - Target voice = match_idx if match found, else free_idx if free found, else steal_ptr.
  - On a steal only, steal_ptr increments mod VOICES (wraps 31->0). Retrigger and free allocation leave steal_ptr unchanged.
  - Write key[target]=key, active[target]=1, reg_cur_key_adr=target, reg_cur_vel_on=vel.
- COMMIT, note-off:
  - If match found: active[match_idx]=0, reg_cur_key_adr=match_idx. reg_cur_vel_on is unchanged.
  - If no match: no table or output changes.
- STROBE (one clock):
  - reg_note_on=1 for a note-on; reg_note_off=1 for a matched note-off; an unmatched note-off gives no pulse.
  - Return to IDLE.
- Strobe timing:
  - Strobes are registered outputs, glitch-free, high exactly one clock. The downstream store clocks on their rising edge.
  - reg_cur_key_adr/reg_cur_vel_on change only at the COMMIT edge. They are stable one full clock before the strobe rises and are held until the next COMMIT.
- Latency (accept edge = T):
  - Strobe rises at edge T+VOICES+2, falls at T+VOICES+3.
  - ev_ready returns high at T+VOICES+3.
  - Latency is identical for every event type, matched or not.
- Events arriving while ev_ready=0 are not accepted. The producer holds ev_valid and the event fields stable until accepted.

Test Plan:
- Reset, then note-on key 60 vel 100 accepted at T → at T+33 adr=0, vel=100; reg_note_on high T+34..T+35; voice_active=0x00000001; ev_ready=1 at T+35.
- Note-on key 62 vel 80 → adr=1, voice_active=0x3. Then note-on key 60 vel 50 → retrigger adr=0, vel=50, steal_ptr still 0.
- Note-off key 60 → reg_note_off pulse with adr=0, voice_active=0x2. Note-off key 99 → no pulse, outputs unchanged, ev_ready back after 35 clocks.
- Fill voices with keys 0..31 (adr 0..31), then note-on key 40 → steals adr 0 and steal_ptr=1. Next key 41 → adr 1. After 32 steals steal_ptr wraps to 0.
- Note-on key 62 with vel 0 → handled as note-off: reg_note_off pulse, adr=1, reg_note_on stays 0.
- Assert reset_reg_N low mid-SCAN → all outputs 0 immediately, no strobe. all_notes_off in IDLE with 5 voices active → voice_active=0 next clock, no strobes, ev_ready low that cycle.
